// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM time-division arbiter.
package sram_arb_pkg;

  // Access pipeline state: pins either idle or carrying one registered access
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } acc_state_e;

  // Who owns the access currently on the pins
  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_CL   = 1'b1
  } owner_e;

  // Level of every active-low SRAM strobe when the bus is idle
  localparam logic PIN_IDLE = 1'b1;

  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 8;
  localparam int DISP_PERIOD_MIN = 2;
  localparam int DISP_PERIOD_MAX = 16;

  // Elaboration-time range check of the top-level parameters
  function automatic bit params_ok(input int n_ch, input int disp_period, input int data_w);
    return (n_ch >= N_CH_MIN) && (n_ch <= N_CH_MAX) &&
           (disp_period >= DISP_PERIOD_MIN) && (disp_period <= DISP_PERIOD_MAX) &&
           (data_w >= 8) && ((data_w % 8) == 0);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Client picker: one-hot grant among N requests.
// SRAM_ARB_RR_EN defined -> round-robin starting after the last winner;
// undefined -> fixed priority, lowest index wins (no pointer state).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

`ifdef SRAM_ARB_RR_EN
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] rr_ptr;
  int               idx;

  // first requester found walking forward from rr_ptr+1, wrapping
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(rr_ptr) + off) % N;
      if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
  end

  // pointer follows the granted index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (gnt[i]) rr_ptr <= PTR_W'(i);
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // lowest asserted index wins
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++)
      if (gnt == '0 && req[i]) gnt[i] = 1'b1;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Time-division owner of the asynchronous SRAM pins. The display gets slot 0
// of every DISP_PERIOD cycles when it asks; all other cycles (and unused
// display slots) go to N_CH request/grant clients.
// Build option: define SRAM_ARB_RR_EN for round-robin client selection,
// otherwise clients are served by fixed priority (lowest index first).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int DISP_PERIOD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_req,
  input  logic [ADDR_W-1:0]          disp_addr,
  output logic [DATA_W-1:0]          disp_rdata,
  output logic                       disp_rvalid,
  input  logic [N_CH-1:0]            cl_req,
  input  logic [N_CH-1:0]            cl_we,
  input  logic [N_CH*ADDR_W-1:0]     cl_addr,
  input  logic [N_CH*DATA_W-1:0]     cl_wdata,
  input  logic [N_CH*(DATA_W/8)-1:0] cl_be,
  output logic [N_CH-1:0]            cl_gnt,
  output logic [DATA_W-1:0]          cl_rdata,
  output logic [N_CH-1:0]            cl_rvalid,
  output logic [ADDR_W-1:0]          SRAM_ADDR,
  inout  wire  [DATA_W-1:0]          SRAM_DQ,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_OE_N,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_UB_N,
  output logic                       SRAM_LB_N
);

  localparam int BE_W   = DATA_W / 8;
  localparam int SLOT_W = $clog2(DISP_PERIOD);
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (!params_ok(N_CH, DISP_PERIOD, DATA_W)) begin : g_param_err
    $error("sram_arbiter: N_CH, DISP_PERIOD or DATA_W out of range");
  end

  logic [SLOT_W-1:0] slot_q;
  logic              disp_win;
  logic [N_CH-1:0]   arb_req;
  logic [N_CH-1:0]   arb_gnt;

  acc_state_e        state_q, state_d;

  // winner mux
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;
  owner_e            win_owner;
  logic [IDX_W-1:0]  win_idx;

  // next pin values
  logic ce_n_d, oe_n_d, ub_n_d, lb_n_d, we_d;

  // registered pins and access tag
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ce_n_q, oe_n_q, ub_n_q, lb_n_q, we_q, dq_oe_q;
  owner_e            owner_q;
  logic [IDX_W-1:0]  idx_q;

  // WE_N shaping: toggle pair tells the first half of a cycle from the second
  logic p_tog, n_tog, we_half;

  logic [DATA_W-1:0] disp_rdata_q, cl_rdata_q;
  logic              disp_rvalid_q;
  logic [N_CH-1:0]   cl_rvalid_q;

  // display slot counter, free-running and wrapping at DISP_PERIOD
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    slot_q <= '0;
    else if (slot_q == SLOT_W'(DISP_PERIOD-1))  slot_q <= '0;
    else                                        slot_q <= slot_q + 1'b1;
  end

  assign disp_win = disp_req && (slot_q == '0);
  assign arb_req  = disp_win ? '0 : cl_req;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  assign cl_gnt = arb_gnt;

  // select the access fields of the slot winner (display by default)
  always_comb begin
    win_addr  = disp_addr;
    win_we    = 1'b0;
    win_wdata = '0;
    win_be    = '1;
    win_owner = OWN_DISP;
    win_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (arb_gnt[i]) begin
        win_addr  = cl_addr[i*ADDR_W +: ADDR_W];
        win_we    = cl_we[i];
        win_wdata = cl_wdata[i*DATA_W +: DATA_W];
        win_be    = cl_be[i*BE_W +: BE_W];
        win_owner = OWN_CL;
        win_idx   = IDX_W'(i);
      end
    end
  end

  // access state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and next pin levels; any winner this cycle means ACCESS next
  always_comb begin
    state_d = IDLE;
    ce_n_d  = PIN_IDLE;
    oe_n_d  = PIN_IDLE;
    ub_n_d  = PIN_IDLE;
    lb_n_d  = PIN_IDLE;
    we_d    = 1'b0;
    if (disp_win || (|arb_gnt)) begin
      state_d = ACCESS;
      ce_n_d  = 1'b0;
      oe_n_d  = win_we;
      ub_n_d  = ~win_be[BE_W-1];
      lb_n_d  = ~win_be[0];
      we_d    = win_we;
    end
  end

  // pin registers; address holds its last value while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ce_n_q  <= PIN_IDLE;
      oe_n_q  <= PIN_IDLE;
      ub_n_q  <= PIN_IDLE;
      lb_n_q  <= PIN_IDLE;
      we_q    <= 1'b0;
      dq_oe_q <= 1'b0;
      owner_q <= OWN_DISP;
      idx_q   <= '0;
    end else begin
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      we_q    <= we_d;
      dq_oe_q <= we_d;
      if (state_d == ACCESS) begin
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        owner_q <= win_owner;
        idx_q   <= win_idx;
      end
    end
  end

  // cycle-phase toggle, flipped on every rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_tog <= 1'b0;
    else     p_tog <= ~p_tog;
  end

  // falling-edge copies: write strobe and phase toggle
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      n_tog   <= 1'b0;
      we_half <= 1'b0;
    end else begin
      n_tog   <= p_tog;
      we_half <= we_q;
    end
  end

  // read data captured at the edge closing ACCESS, pulsed one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_rvalid_q <= 1'b0;
      cl_rvalid_q   <= '0;
      disp_rdata_q  <= '0;
      cl_rdata_q    <= '0;
    end else begin
      disp_rvalid_q <= 1'b0;
      cl_rvalid_q   <= '0;
      if (state_q == ACCESS && !we_q) begin
        if (owner_q == OWN_DISP) begin
          disp_rvalid_q <= 1'b1;
          disp_rdata_q  <= SRAM_DQ;
        end else begin
          cl_rdata_q <= SRAM_DQ;
          for (int i = 0; i < N_CH; i++)
            cl_rvalid_q[i] <= (idx_q == IDX_W'(i));
        end
      end
    end
  end

  // WE_N low only while a write is on the pins and past the falling edge
  assign SRAM_WE_N = ~(we_q & we_half & (p_tog == n_tog));

  assign SRAM_ADDR   = addr_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_UB_N   = ub_n_q;
  assign SRAM_LB_N   = lb_n_q;
  assign SRAM_DQ     = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

  assign disp_rdata  = disp_rdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign cl_rdata    = cl_rdata_q;
  assign cl_rvalid   = cl_rvalid_q;

endmodule
